// File: rtl/simple_alu.sv
// Two-stage registered ALU: stage 1 captures operands/opcode on en_i,
// stage 2 registers the result and flags on en_o.
module simple_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             en_o,
  input  logic [1:0]       select_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  localparam int unsigned EXT_W = WIDTH + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [EXT_W-1:0] sum_c;
  logic [EXT_W-1:0] diff_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c;

  // Extended-width add/sub: the extra MSB is carry-out or borrow respectively.
  always_comb begin
    sum_c  = EXT_W'(a_q) + EXT_W'(b_q);
    diff_c = EXT_W'(a_q) - EXT_W'(b_q);
    res_c  = '0;
    c_c    = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
      end
      OP_SUB: begin
        res_c = diff_c[WIDTH-1:0];
        c_c   = diff_c[WIDTH];
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      default: begin
        res_c = '0;
        c_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (en_i) begin
      a_d  = a;
      b_d  = b;
      op_d = select_op;
    end
    if (en_o) begin
      out_d   = res_c;
      carry_d = c_c;
      zero_d  = (res_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_simple_alu.sv
// Scoreboard bench for simple_alu: driver pushes the expected post-edge
// outputs from an arithmetic reference model; a monitor pops and compares.
module tb_simple_alu;

  localparam int unsigned WIDTH = 4;
  localparam int          MODV  = 16;

  logic             clk;
  logic             rst;
  logic             en_i;
  logic             en_o;
  logic [1:0]       select_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference model state: captured operands and visible outputs.
  int m_a, m_b, m_op, m_out, m_c, m_z;

  typedef struct {
    int out;
    int c;
    int z;
    int step;
  } exp_t;

  exp_t exp_q[$];

  simple_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .en_o      (en_o),
    .select_op (select_op),
    .a         (a),
    .b         (b),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void alu_ref(input int op, input int x, input int y,
                                  output int res, output int c);
    int t;
    case (op)
      0: begin t = x + y; res = t % MODV; c = (t >= MODV) ? 1 : 0; end
      1: begin res = (x - y + MODV) % MODV; c = (x < y) ? 1 : 0; end
      2: begin res = x & y; c = 0; end
      default: begin res = x | y; c = 0; end
    endcase
  endfunction

  // Apply one cycle of stimulus at the falling edge and predict the result.
  task automatic step(input int r, input int ei, input int eo,
                      input int sel, input int xa, input int xb);
    int res, c;
    exp_t e;
    @(negedge clk);
    rst       = r[0];
    en_i      = ei[0];
    en_o      = eo[0];
    select_op = 2'(sel);
    a         = 4'(xa);
    b         = 4'(xb);
    step_no++;
    if (r != 0) begin
      m_a = 0; m_b = 0; m_op = 0;
      m_out = 0; m_c = 0; m_z = 0;
    end else begin
      if (eo != 0) begin
        alu_ref(m_op, m_a, m_b, res, c);
        m_out = res;
        m_c   = c;
        m_z   = (res == 0) ? 1 : 0;
      end
      if (ei != 0) begin
        m_a = xa % MODV; m_b = xb % MODV; m_op = sel % 4;
      end
    end
    e.out = m_out; e.c = m_c; e.z = m_z; e.step = step_no;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are live every cycle, compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== 4'(e.out) || carry !== e.c[0] || zero !== e.z[0]) begin
          errors++;
          $display("FAIL step%0d: got out=%h carry=%b zero=%b, expected out=%h carry=%0d zero=%0d",
                   e.step, out, carry, zero, e.out, e.c, e.z);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1; en_i = 1'b0; en_o = 1'b0; select_op = 2'b00; a = '0; b = '0;

    // Reset dominates enables; then en_o alone recomputes 0+0.
    step(1, 1, 1, 0, 5, 7);
    step(1, 1, 1, 0, 5, 7);
    step(0, 0, 1, 0, 5, 7);

    // Add, then add with carry-out and zero.
    step(0, 1, 0, 0, 1, 3);
    step(0, 0, 1, 0, 9, 9);
    step(0, 1, 0, 0, 15, 1);
    step(0, 0, 1, 0, 0, 0);

    // Overlapped capture and output.
    step(0, 1, 0, 0, 1, 3);
    step(0, 1, 1, 1, 3, 2);
    step(0, 1, 1, 2, 3, 3);
    step(0, 1, 1, 2, 3, 3);

    // Subtract wrap and equal operands.
    step(0, 1, 0, 1, 2, 3);
    step(0, 1, 1, 1, 3, 3);
    step(0, 0, 1, 1, 0, 0);

    // Logic ops.
    step(0, 1, 0, 2, 10, 6);
    step(0, 1, 1, 3, 10, 6);
    step(0, 0, 1, 3, 0, 0);

    // Hold: en_i low recomputes held operands; en_o low freezes outputs.
    step(0, 0, 1, 0, 5, 9);
    step(0, 0, 1, 1, 12, 4);
    for (int i = 0; i < 10; i++)
      step(0, $urandom_range(0, 1), 0, $urandom_range(0, 3),
           $urandom_range(0, 15), $urandom_range(0, 15));

    // Reset mid-operation discards captured operands.
    step(0, 1, 0, 0, 9, 9);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // Random traffic, including equal and extreme operands and rare resets.
    for (int i = 0; i < 300; i++) begin
      int xa, xb;
      xa = $urandom_range(0, 15);
      xb = ($urandom_range(0, 7) == 0) ? xa : $urandom_range(0, 15);
      step(($urandom_range(0, 31) == 0) ? 1 : 0, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3), xa, xb);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
